lemming_pack: RTL and testbench
===============================

// Module: lemming_pack
// PURPOSE
//  N independent Lemming walker FSMs in one block, each driven by its own terrain/command inputs.
//  Each lane implements: walk left/right, fall, dig and splat.
//  Splat threshold and lane count are parameters.
//  Adds a per-lane revive command, a one-cycle splat event pulse and a live-lemming population count.
//  Sits between the level terrain model and the score/display logic.
// PARAMETERS
//  N_LEM       4   number of independent lemming lanes (>=1)
//  FALL_LIMIT  20  a fall whose count exceeds this value splats on landing (>=1)
//  CNT_W       $clog2(FALL_LIMIT+2)  fall counter width (derived, localparam)
//  POP_W       $clog2(N_LEM+1)       alive_count width (derived, localparam)
// PORTS
//  clk         in   1      rising-edge clock
//  areset_n    in   1      async reset, active low
//  bump_left   in   N_LEM  per-lane obstacle on left
//  bump_right  in   N_LEM  per-lane obstacle on right
//  ground      in   N_LEM  per-lane ground present (1 = standing surface)
//  dig         in   N_LEM  per-lane dig command
//  revive      in   N_LEM  per-lane revive command (honoured only in SPLAT)
//  walk_left   out  N_LEM  lane in WALK_L
//  walk_right  out  N_LEM  lane in WALK_R
//  aaah        out  N_LEM  lane in FALL_L or FALL_R
//  digging     out  N_LEM  lane in DIG_L or DIG_R
//  splat_evt   out  N_LEM  registered 1-cycle pulse on the cycle a lane enters SPLAT
//  alive_count out  POP_W  number of lanes not in SPLAT (combinational popcount of state)
// BEHAVIOUR
//  Reset:
//   - areset_n=0: every lane goes to WALK_L, fall_cnt=0, splat_evt=0.
//   - Outputs then read walk_left=all 1s, others 0, alive_count=N_LEM.
//   - Deassertion is sampled at the next clk edge.
//  States (per lane): WALK_L, WALK_R, FALL_L, FALL_R, DIG_L, DIG_R, SPLAT. Moore outputs, decoded from state only.
//  Transition priority in WALK_x: ~ground > dig > bump.
//   - WALK_L: ~ground->FALL_L; else dig->DIG_L; else bump_left->WALK_R; else stay. bump_right ignored.
//   - WALK_R: mirror. ~ground->FALL_R; dig->DIG_R; bump_right->WALK_L.
//   - Simultaneous bump_left & bump_right: only the bump on the walking side counts.
//  FALL_x:
//   - ground=0: stay.
//   - ground=1: fall_cnt>FALL_LIMIT -> SPLAT, else -> WALK_x (same direction).
//   - Bumps and dig are ignored while falling.
//  DIG_x: ~ground->FALL_x; else stay. Bumps and dig are ignored.
//  SPLAT: stay unless revive=1, which goes to WALK_L next cycle. All four outputs are 0 in SPLAT.
//  fall_cnt (per lane, CNT_W bits):
//   - ground=0: increments each clk, saturating at FALL_LIMIT+1 (never wraps).
//   - ground=1: cleared. Also cleared in SPLAT.
//   - Counts all ground-low cycles, including the WALK/DIG cycle that launches the fall.
//   - So ground low for exactly FALL_LIMIT consecutive cycles lands safely; FALL_LIMIT+1 splats.
//  splat_evt[i]: 1 for exactly the one cycle where state==SPLAT and the previous state != SPLAT.
//  Lanes are fully independent: no shared state except the alive_count sum.
//  Reset asserted mid-fall or mid-dig aborts immediately to WALK_L with no splat_evt.
// TESTING
//  1 reset: areset_n=0 -> walk_left=4'b1111, aaah=0, alive_count=4. Release with ground=1111 -> lanes stay WALK_L.
//  2 bump/priority:
//    - lane0 WALK_L, bump_left=1 & bump_right=1 -> WALK_R next cycle.
//    - Then dig=1 & bump_right=1 -> DIG_R, digging[0]=1.
//  3 fall boundary:
//    - lane1 ground=0 for 20 cycles, then 1 -> aaah[1]=1 during fall, then walk_left[1]=1, alive_count=4.
//    - Repeat with 21 cycles -> SPLAT, splat_evt[1] high 1 cycle, alive_count=3.
//  4 dig-through:
//    - lane2 DIG_R, ground=0 for 5 cycles -> FALL_R, aaah[2]=1.
//    - ground=1 -> walk_right[2]=1.
//  5 revive/saturation:
//    - lane3 ground=0 for 300 cycles (counter must not wrap), then ground=1 -> SPLAT.
//    - revive=1 -> walk_left[3]=1 next cycle, alive_count back to 4.
//  6 reset mid-fall: lane0 falling 15 cycles, pulse areset_n low -> WALK_L. A fresh 20-cycle fall lands safely.

Source files
------------

// File: rtl/lemming_pack.sv
// ============================================================================
// Module      : lemming_pack
// Description : N independent Lemming walker FSMs with revive, splat pulse and
//               live population count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lemming_pack #(
  parameter int  N_LEM      = 4,
  parameter int  FALL_LIMIT = 20,
  localparam int CNT_W      = $clog2(FALL_LIMIT + 2),
  localparam int POP_W      = $clog2(N_LEM + 1)
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic [N_LEM-1:0] bump_left,
  input  logic [N_LEM-1:0] bump_right,
  input  logic [N_LEM-1:0] ground,
  input  logic [N_LEM-1:0] dig,
  input  logic [N_LEM-1:0] revive,
  output logic [N_LEM-1:0] walk_left,
  output logic [N_LEM-1:0] walk_right,
  output logic [N_LEM-1:0] aaah,
  output logic [N_LEM-1:0] digging,
  output logic [N_LEM-1:0] splat_evt,
  output logic [POP_W-1:0] alive_count
);

  localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(FALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_CNT_LIMIT = CNT_W'(FALL_LIMIT);

  typedef enum logic [2:0] {
    S_WALK_L = 3'd0,
    S_WALK_R = 3'd1,
    S_FALL_L = 3'd2,
    S_FALL_R = 3'd3,
    S_DIG_L  = 3'd4,
    S_DIG_R  = 3'd5,
    S_SPLAT  = 3'd6
  } state_t;

  logic [N_LEM-1:0] w_alive_vec;

  generate
    for (genvar i = 0; i < N_LEM; i++) begin : g_lane
      state_t           r_state;
      state_t           w_next;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
      logic             r_evt;

      always_comb begin
        w_next = r_state;
        unique case (r_state)
          S_WALK_L: begin
            if (!ground[i])         w_next = S_FALL_L;
            else if (dig[i])        w_next = S_DIG_L;
            else if (bump_left[i])  w_next = S_WALK_R;
          end
          S_WALK_R: begin
            if (!ground[i])         w_next = S_FALL_R;
            else if (dig[i])        w_next = S_DIG_R;
            else if (bump_right[i]) w_next = S_WALK_L;
          end
          S_FALL_L: if (ground[i]) w_next = (r_cnt > c_CNT_LIMIT) ? S_SPLAT : S_WALK_L;
          S_FALL_R: if (ground[i]) w_next = (r_cnt > c_CNT_LIMIT) ? S_SPLAT : S_WALK_R;
          S_DIG_L:  if (!ground[i]) w_next = S_FALL_L;
          S_DIG_R:  if (!ground[i]) w_next = S_FALL_R;
          S_SPLAT:  if (revive[i]) w_next = S_WALK_L;
          default:  w_next = S_WALK_L;
        endcase
      end

      // Counter counts every ground-low cycle, including the launch cycle.
      always_comb begin
        w_cnt_next = r_cnt;
        if (r_state == S_SPLAT || ground[i]) w_cnt_next = '0;
        else if (r_cnt != c_CNT_MAX)         w_cnt_next = r_cnt + CNT_W'(1);
      end

      always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
          r_state <= S_WALK_L;
          r_cnt   <= '0;
          r_evt   <= 1'b0;
        end else begin
          r_state <= w_next;
          r_cnt   <= w_cnt_next;
          r_evt   <= (w_next == S_SPLAT) && (r_state != S_SPLAT);
        end
      end

      assign walk_left[i]   = (r_state == S_WALK_L);
      assign walk_right[i]  = (r_state == S_WALK_R);
      assign aaah[i]        = (r_state == S_FALL_L) || (r_state == S_FALL_R);
      assign digging[i]     = (r_state == S_DIG_L)  || (r_state == S_DIG_R);
      assign splat_evt[i]   = r_evt;
      assign w_alive_vec[i] = (r_state != S_SPLAT);
    end
  endgenerate

  always_comb begin
    alive_count = '0;
    for (int k = 0; k < N_LEM; k++) begin
      alive_count = alive_count + POP_W'(w_alive_vec[k]);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lemming_pack.sv
// Self-checking bench for lemming_pack: directed table, corner sequences and
// random traffic against a run-length based reference model.
`default_nettype none

module tb_lemming_pack;
  localparam int N   = 4;
  localparam int LIM = 20;
  localparam int ACT_WALK = 0, ACT_FALL = 1, ACT_DIG = 2, ACT_DEAD = 3;

  logic         clk = 1'b0;
  logic         areset_n = 1'b0;
  logic [N-1:0] bump_left = '0, bump_right = '0, ground = '1, dig = '0, revive = '0;
  logic [N-1:0] walk_left, walk_right, aaah, digging, splat_evt;
  logic [2:0]   alive_count;

  int n_checks = 0;
  int n_err    = 0;

  int m_act   [N];
  bit m_right [N];
  int m_run   [N];
  bit m_evt   [N];

  typedef struct {
    logic [N-1:0] bl, br, g, d, rv;
    logic [N-1:0] wl, wr, ah, dg;
    int           alive;
  } vec_t;
  vec_t tbl [8];

  lemming_pack #(.N_LEM(N), .FALL_LIMIT(LIM)) dut (
    .clk(clk), .areset_n(areset_n),
    .bump_left(bump_left), .bump_right(bump_right), .ground(ground),
    .dig(dig), .revive(revive),
    .walk_left(walk_left), .walk_right(walk_right), .aaah(aaah),
    .digging(digging), .splat_evt(splat_evt), .alive_count(alive_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = ACT_WALK; m_right[i] = 0; m_run[i] = 0; m_evt[i] = 0;
    end
  endfunction

  // A lemming dies when it lands after more than LIM consecutive ground-low cycles.
  function automatic void model_step(input logic [N-1:0] bl, br, g, d, rv);
    for (int i = 0; i < N; i++) begin
      int prev_run;
      m_evt[i] = 0;
      if (m_act[i] == ACT_DEAD) begin
        m_run[i] = 0;
        if (rv[i]) begin m_act[i] = ACT_WALK; m_right[i] = 0; end
        continue;
      end
      prev_run = m_run[i];
      m_run[i] = g[i] ? 0 : m_run[i] + 1;
      case (m_act[i])
        ACT_WALK: begin
          if (!g[i])      m_act[i] = ACT_FALL;
          else if (d[i])  m_act[i] = ACT_DIG;
          else if (m_right[i] ? br[i] : bl[i]) m_right[i] = !m_right[i];
        end
        ACT_FALL: if (g[i]) begin
          if (prev_run > LIM) begin m_act[i] = ACT_DEAD; m_evt[i] = 1; m_run[i] = 0; end
          else m_act[i] = ACT_WALK;
        end
        ACT_DIG: if (!g[i]) m_act[i] = ACT_FALL;
        default: ;
      endcase
    end
  endfunction

  task automatic check_model(input string tag);
    logic [N-1:0] ewl, ewr, eah, edg, eev;
    int alive = 0;
    for (int i = 0; i < N; i++) begin
      ewl[i] = (m_act[i] == ACT_WALK) && !m_right[i];
      ewr[i] = (m_act[i] == ACT_WALK) &&  m_right[i];
      eah[i] = (m_act[i] == ACT_FALL);
      edg[i] = (m_act[i] == ACT_DIG);
      eev[i] = m_evt[i];
      if (m_act[i] != ACT_DEAD) alive++;
    end
    chk({tag, ".walk_left"},  32'(walk_left),  32'(ewl));
    chk({tag, ".walk_right"}, 32'(walk_right), 32'(ewr));
    chk({tag, ".aaah"},       32'(aaah),       32'(eah));
    chk({tag, ".digging"},    32'(digging),    32'(edg));
    chk({tag, ".splat_evt"},  32'(splat_evt),  32'(eev));
    chk({tag, ".alive"},      32'(alive_count), 32'(alive));
  endtask

  task automatic step(input string tag, input logic [N-1:0] bl, br, g, d, rv);
    @(negedge clk);
    bump_left = bl; bump_right = br; ground = g; dig = d; revive = rv;
    model_step(bl, br, g, d, rv);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset_n = 1'b0;
    bump_left = '0; bump_right = '0; ground = '1; dig = '0; revive = '0;
    model_reset();
    #2;
    chk("rst.walk_left", 32'(walk_left), 32'hF);
    chk("rst.aaah",      32'(aaah),      32'h0);
    chk("rst.splat_evt", 32'(splat_evt), 32'h0);
    chk("rst.alive",     32'(alive_count), 32'd4);
    @(negedge clk);
    areset_n = 1'b1;
    step("rst_release", '0, '0, '1, '0, '0);
    chk("rst_release.stay_wl", 32'(walk_left), 32'hF);
  endtask

  initial begin
    int pit [N];
    logic [N-1:0] g, bl, br, d, rv;

    tbl[0] = '{4'b0001, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4};
    tbl[1] = '{4'b0000, 4'b0001, 4'b1111, 4'b0001, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 4};
    tbl[2] = '{4'b0001, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 4};
    tbl[3] = '{4'b0000, 4'b0000, 4'b1111, 4'b0100, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0101, 4};
    tbl[4] = '{4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0101, 4'b0000, 4};
    tbl[5] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4};
    tbl[6] = '{4'b1000, 4'b0001, 4'b1111, 4'b0000, 4'b0000, 4'b0111, 4'b1000, 4'b0000, 4'b0000, 4};
    tbl[7] = '{4'b0000, 4'b1000, 4'b1111, 4'b0010, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0010, 4};

    do_reset();
    for (int k = 0; k < 8; k++) begin
      step($sformatf("tbl%0d", k), tbl[k].bl, tbl[k].br, tbl[k].g, tbl[k].d, tbl[k].rv);
      chk($sformatf("tbl%0d.wl", k),    32'(walk_left),   32'(tbl[k].wl));
      chk($sformatf("tbl%0d.wr", k),    32'(walk_right),  32'(tbl[k].wr));
      chk($sformatf("tbl%0d.aaah", k),  32'(aaah),        32'(tbl[k].ah));
      chk($sformatf("tbl%0d.dig", k),   32'(digging),     32'(tbl[k].dg));
      chk($sformatf("tbl%0d.alive", k), 32'(alive_count), 32'(tbl[k].alive));
    end

    // Fall boundary on lane 1: LIM cycles lands, LIM+1 splats.
    do_reset();
    for (int c = 0; c < LIM; c++) begin
      step("fall20", '0, '0, 4'b1101, '0, '0);
      chk("fall20.aaah1", 32'(aaah[1]), 32'd1);
    end
    step("land20", '0, '0, 4'b1111, '0, '0);
    chk("land20.wl1",   32'(walk_left[1]), 32'd1);
    chk("land20.alive", 32'(alive_count),  32'd4);
    for (int c = 0; c < LIM + 1; c++) step("fall21", '0, '0, 4'b1101, '0, '0);
    step("land21", '0, '0, 4'b1111, '0, '0);
    chk("land21.evt1",  32'(splat_evt[1]), 32'd1);
    chk("land21.alive", 32'(alive_count),  32'd3);
    step("splat_hold", '0, '0, 4'b1111, '0, '0);
    chk("splat_hold.evt1", 32'(splat_evt[1]), 32'd0);
    chk("splat_hold.wl1",  32'(walk_left[1]),  32'd0);
    step("revive1", '0, '0, 4'b1111, '0, 4'b0010);
    chk("revive1.wl1", 32'(walk_left[1]), 32'd1);

    // Dig-through on lane 2.
    step("l2_turn", 4'b0100, '0, 4'b1111, '0, '0);
    step("l2_dig",  '0, '0, 4'b1111, 4'b0100, '0);
    chk("l2_dig.digging2", 32'(digging[2]), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step("l2_fall", 4'b0100, 4'b0100, 4'b1011, 4'b0100, '0);
      chk("l2_fall.aaah2", 32'(aaah[2]), 32'd1);
    end
    step("l2_land", '0, '0, 4'b1111, '0, '0);
    chk("l2_land.wr2", 32'(walk_right[2]), 32'd1);

    // Long fall on lane 3: counter must saturate, not wrap.
    for (int c = 0; c < 300; c++) step("l3_long", '0, '0, 4'b0111, '0, '0);
    step("l3_land", '0, '0, 4'b1111, '0, '0);
    chk("l3_land.evt3",  32'(splat_evt[3]), 32'd1);
    chk("l3_land.alive", 32'(alive_count),  32'd3);
    step("l3_revive", '0, '0, 4'b1111, '0, 4'b1000);
    chk("l3_revive.wl3",   32'(walk_left[3]), 32'd1);
    chk("l3_revive.alive", 32'(alive_count),  32'd4);

    // Reset mid-fall on lane 0, then a fresh LIM-cycle fall must land safely.
    do_reset();
    for (int c = 0; c < 15; c++) step("l0_pre", '0, '0, 4'b1110, '0, '0);
    @(negedge clk);
    areset_n = 1'b0;
    ground = 4'b1111;
    model_reset();
    #2;
    chk("midrst.walk_left", 32'(walk_left), 32'hF);
    chk("midrst.aaah",      32'(aaah),      32'h0);
    chk("midrst.evt",       32'(splat_evt), 32'h0);
    @(negedge clk);
    areset_n = 1'b1;
    for (int c = 0; c < LIM; c++) step("l0_fresh", '0, '0, 4'b1110, '0, '0);
    step("l0_land", '0, '0, 4'b1111, '0, '0);
    chk("l0_land.wl0",   32'(walk_left[0]), 32'd1);
    chk("l0_land.alive", 32'(alive_count),  32'd4);

    // Random traffic against the model.
    for (int i = 0; i < N; i++) pit[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pit[i] > 0) begin
          g[i] = 1'b0; pit[i]--;
        end else if ($urandom_range(0, 9) == 0) begin
          g[i] = 1'b0; pit[i] = int'($urandom_range(1, 30)) - 1;
        end else begin
          g[i] = 1'b1;
        end
        bl[i] = ($urandom_range(0, 3) == 0);
        br[i] = ($urandom_range(0, 3) == 0);
        d[i]  = ($urandom_range(0, 7) == 0);
        rv[i] = ($urandom_range(0, 5) == 0);
      end
      step("rand", bl, br, g, d, rv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
